// File: rtl/lvds_frame_send.sv
// LVDS-domain frame transmitter: reads 32-bit words from the frame buffer and streams them
// LSB nibble first on LVDS_OUT, one nibble per LVDS_CLK, with a frame strobe and done toggle.
module lvds_frame_send #(
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned NIB_PER_WORD = 8,
    parameter logic [3:0]  IDLE_PATTERN = 4'h0
) (
    input  logic              LVDS_CLK,
    input  logic              lvds_resetn,
    input  logic              start_toggle,
    input  logic [ADDR_W-1:0] len_words,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [31:0]       rd_data,
    output logic [3:0]        LVDS_OUT,
    output logic              LVDS_FRAME,
    output logic              busy,
    output logic              done_toggle
);

    localparam int unsigned  NIB_W    = $clog2(NIB_PER_WORD);
    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB_PER_WORD - 1);
    // Read issued two nibbles early so the word lands exactly as nibble 7 leaves.
    localparam logic [NIB_W-1:0] NIB_PRE  = NIB_W'(NIB_PER_WORD - 3);

    typedef enum logic [1:0] {StIdle, StLoad, StPrime, StSend} state_e;

    state_e            r_state, w_state_next;
    logic [2:0]        r_sync;
    logic [31:0]       r_shift, w_shift_next;
    logic [NIB_W-1:0]  r_nib, w_nib_next;
    logic [ADDR_W-1:0] r_word, w_word_next;
    logic [ADDR_W-1:0] r_last, w_last_next;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_next;
    logic              r_rd_en, w_rd_en_next;
    logic              r_frame, w_frame_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic              w_start_pulse;

    assign w_start_pulse = r_sync[1] ^ r_sync[2];

    always_ff @(posedge LVDS_CLK or negedge lvds_resetn) begin
        if (!lvds_resetn) begin
            r_state   <= StIdle;
            r_sync    <= 3'b000;
            r_shift   <= {28'h0, IDLE_PATTERN};
            r_nib     <= '0;
            r_word    <= '0;
            r_last    <= '0;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b0;
            r_frame   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sync    <= {r_sync[1:0], start_toggle};
            r_shift   <= w_shift_next;
            r_nib     <= w_nib_next;
            r_word    <= w_word_next;
            r_last    <= w_last_next;
            r_rd_addr <= w_rd_addr_next;
            r_rd_en   <= w_rd_en_next;
            r_frame   <= w_frame_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_nib_next     = r_nib;
        w_word_next    = r_word;
        w_last_next    = r_last;
        w_rd_addr_next = r_rd_addr;
        w_rd_en_next   = 1'b0;
        w_frame_next   = r_frame;
        w_busy_next    = r_busy;
        w_done_next    = r_done;
        unique case (r_state)
            StIdle: begin
                if (w_start_pulse) begin
                    // Last word index; len 0 wraps to 2^ADDR_W - 1, i.e. a full buffer.
                    w_last_next    = len_words - ADDR_W'(1);
                    w_busy_next    = 1'b1;
                    w_rd_en_next   = 1'b1;
                    w_rd_addr_next = '0;
                    w_state_next   = StLoad;
                end
            end
            StLoad: begin
                w_state_next = StPrime;
            end
            StPrime: begin
                w_shift_next = rd_data;
                w_nib_next   = '0;
                w_word_next  = '0;
                w_frame_next = 1'b1;
                w_state_next = StSend;
            end
            StSend: begin
                if (r_nib == NIB_LAST) begin
                    if (r_word == r_last) begin
                        w_shift_next = {28'h0, IDLE_PATTERN};
                        w_frame_next = 1'b0;
                        w_busy_next  = 1'b0;
                        w_done_next  = ~r_done;
                        w_state_next = StIdle;
                    end else begin
                        w_shift_next = rd_data;
                        w_nib_next   = '0;
                        w_word_next  = r_word + ADDR_W'(1);
                    end
                end else begin
                    w_shift_next = {4'h0, r_shift[31:4]};
                    w_nib_next   = r_nib + NIB_W'(1);
                    if (r_nib == NIB_PRE && r_word != r_last) begin
                        w_rd_en_next   = 1'b1;
                        w_rd_addr_next = r_word + ADDR_W'(1);
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign LVDS_OUT    = r_shift[3:0];
    assign LVDS_FRAME  = r_frame;
    assign busy        = r_busy;
    assign rd_en       = r_rd_en;
    assign rd_addr     = r_rd_addr;
    assign done_toggle = r_done;

endmodule

// File: tb/tb_lvds_frame_send.sv
// Bench for lvds_frame_send: random buffer contents, expected nibble stream and read addresses
// derived directly from the buffer words and frame length.
module tb_lvds_frame_send;

    localparam logic [3:0] IDLE = 4'h0;

    logic        LVDS_CLK = 1'b0;
    logic        lvds_resetn;
    logic        start_toggle;
    logic [6:0]  len_words;
    logic [6:0]  rd_addr;
    logic        rd_en;
    logic [31:0] rd_data;
    logic [3:0]  LVDS_OUT;
    logic        LVDS_FRAME;
    logic        busy;
    logic        done_toggle;

    logic [31:0] mem [128];
    logic [6:0]  rd_log [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        exp_done = 1'b0;

    lvds_frame_send #(
        .ADDR_W       (7),
        .NIB_PER_WORD (8),
        .IDLE_PATTERN (4'h0)
    ) dut (
        .LVDS_CLK     (LVDS_CLK),
        .lvds_resetn  (lvds_resetn),
        .start_toggle (start_toggle),
        .len_words    (len_words),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .LVDS_OUT     (LVDS_OUT),
        .LVDS_FRAME   (LVDS_FRAME),
        .busy         (busy),
        .done_toggle  (done_toggle)
    );

    always #5 LVDS_CLK = ~LVDS_CLK;

    // Synchronous-read buffer: data one cycle after rd_en; every read is logged.
    always @(posedge LVDS_CLK) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            rd_log.push_back(rd_addr);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int w = 0; w < 128; w++) mem[w] = $urandom;
    endtask

    task automatic run_frame(input logic [6:0] lw, input int retog_at);
        int         n;
        logic [3:0] nibs [$];
        logic [6:0] addrs [$];
        logic       pref;
        n = (lw == 7'd0) ? 128 : int'(lw);
        for (int w = 0; w < n; w++) begin
            addrs.push_back(7'(w));
            for (int k = 0; k < 8; k++) nibs.push_back(mem[w][4*k +: 4]);
        end
        rd_log.delete();
        @(negedge LVDS_CLK);
        len_words    = lw;
        start_toggle = ~start_toggle;
        repeat (2) @(negedge LVDS_CLK);
        chk("busy_sync", busy, 0);
        @(negedge LVDS_CLK);
        chk("busy_load", busy, 1);
        chk("rd_en_load", rd_en, 1);
        chk("rd_addr_load", rd_addr, 0);
        chk("frame_load", LVDS_FRAME, 0);
        @(negedge LVDS_CLK);
        chk("frame_prime", LVDS_FRAME, 0);
        chk("rd_en_prime", rd_en, 0);
        for (int i = 0; i < n * 8; i++) begin
            @(negedge LVDS_CLK);
            chk($sformatf("frame_c%0d", i), LVDS_FRAME, 1);
            chk($sformatf("out_c%0d", i), LVDS_OUT, nibs[i]);
            chk($sformatf("busy_c%0d", i), busy, 1);
            pref = (i % 8 == 6) && (i / 8 < n - 1);
            chk($sformatf("rd_en_c%0d", i), rd_en, pref);
            if (pref) chk($sformatf("rd_addr_c%0d", i), rd_addr, i / 8 + 1);
            if (i == 2) len_words = 7'($urandom);
            if (i == retog_at) start_toggle = ~start_toggle;
        end
        exp_done = ~exp_done;
        @(negedge LVDS_CLK);
        chk("frame_end", LVDS_FRAME, 0);
        chk("out_end", LVDS_OUT, IDLE);
        chk("busy_end", busy, 0);
        chk("done_end", done_toggle, exp_done);
        repeat (12) @(negedge LVDS_CLK);
        chk("frame_after", LVDS_FRAME, 0);
        chk("busy_after", busy, 0);
        chk("done_after", done_toggle, exp_done);
        chk("rd_count", rd_log.size(), n);
        for (int i = 0; i < n && i < rd_log.size(); i++)
            chk($sformatf("rd_addr_log%0d", i), rd_log[i], addrs[i]);
    endtask

    initial begin
        lvds_resetn  = 1'b0;
        start_toggle = 1'b0;
        len_words    = 7'd0;
        rd_data      = 32'h0;
        fill_random();
        #12;
        chk("rst_out", LVDS_OUT, IDLE);
        chk("rst_frame", LVDS_FRAME, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_done", done_toggle, 0);
        @(negedge LVDS_CLK);
        lvds_resetn = 1'b1;
        repeat (20) @(negedge LVDS_CLK);
        chk("idle_out", LVDS_OUT, IDLE);
        chk("idle_frame", LVDS_FRAME, 0);
        chk("idle_rd_en", rd_en, 0);
        chk("idle_busy", busy, 0);

        // Single word.
        mem[0] = 32'h87654321;
        run_frame(7'd1, -1);

        // Three words back to back.
        mem[0] = 32'h0000000F;
        mem[1] = 32'hF0000000;
        mem[2] = 32'hA5A5A5A5;
        run_frame(7'd3, -1);

        // Full buffer.
        fill_random();
        run_frame(7'd0, -1);

        // Start request during a frame is dropped.
        fill_random();
        run_frame(7'd2, 10);

        // Reset at frame cycle 5, then a clean frame from word 0.
        fill_random();
        @(negedge LVDS_CLK);
        len_words    = 7'd2;
        start_toggle = ~start_toggle;
        repeat (9) @(negedge LVDS_CLK);
        chk("mid_frame_c5", LVDS_FRAME, 1);
        #1;
        lvds_resetn  = 1'b0;
        start_toggle = 1'b0;
        #1;
        chk("mid_rst_frame", LVDS_FRAME, 0);
        chk("mid_rst_out", LVDS_OUT, IDLE);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_done", done_toggle, 0);
        exp_done = 1'b0;
        repeat (3) @(negedge LVDS_CLK);
        lvds_resetn = 1'b1;
        repeat (3) @(negedge LVDS_CLK);
        run_frame(7'd2, -1);

        // Random lengths and contents.
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_frame(7'($urandom_range(1, 9)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lvds_frame_send.md
Name: lvds_frame_send

Overview:
- LVDS-domain transmitter. It is the counterpart of the LVDS capture path.
- On a start request from the AXI domain, it reads 32-bit words from a dual-port frame buffer through the buffer's read port.
- It serialises each word as eight 4-bit nibbles on LVDS_OUT, one nibble per LVDS_CLK, with a frame-valid strobe.
- Completion is signalled back to the AXI domain by a toggle. The block is used for loopback test and for driving the downstream LVDS link.

Parameters:
- ADDR_W, 7, buffer word-address width; max frame = 2^ADDR_W words.
- NIB_PER_WORD, 8, nibbles per 32-bit word (fixed; 32/4).
- IDLE_PATTERN, 4'h0, value driven on LVDS_OUT when no frame is in progress.

Ports:
- LVDS_CLK  in  1  transmit clock; all logic is on its rising edge.
- lvds_resetn  in  1  asynchronous, active-low reset.
- start_toggle  in  1  AXI-domain toggle; each level change requests one frame. Asynchronous to LVDS_CLK.
- len_words  in  ADDR_W  frame length in words; 0 = 2^ADDR_W. Quasi-static; sampled at frame start.
- rd_addr  out  ADDR_W  buffer read word address.
- rd_en  out  1  buffer read enable.
- rd_data  in  32  buffer read data; valid exactly 1 cycle after rd_en.
- LVDS_OUT  out  4  serial nibble data.
- LVDS_FRAME  out  1  high while LVDS_OUT carries frame nibbles.
- busy  out  1  high from start detection until the frame ends.
- done_toggle  out  1  toggles once per completed frame (to AXI domain).

Behaviour:
- Reset: lvds_resetn is asynchronous, active-low, clock LVDS_CLK. All outputs are registered. Reset values:
  - LVDS_OUT = IDLE_PATTERN
  - LVDS_FRAME = 0, busy = 0, rd_en = 0, rd_addr = 0, done_toggle = 0
  - sync chain = 0, state = IDLE
- Start synchroniser:
  - 2-FF synchroniser on start_toggle, plus a third flop for edge detection.
  - start_pulse = sync2 XOR sync3.
  - A toggle edge is seen 3 LVDS_CLK cycles after the input change.
- FSM states: IDLE, LOAD, PRIME, SEND.
  - IDLE:
    - LVDS_OUT = IDLE_PATTERN, LVDS_FRAME = 0.
    - On start_pulse: latch len_words (0 maps to 2^ADDR_W), set busy = 1, go to LOAD.
  - LOAD (1 cycle): rd_en = 1, rd_addr = 0 -> PRIME.
  - PRIME (1 cycle): rd_data valid; shift register <= rd_data, nib_cnt <= 0, word_cnt <= 0 -> SEND.
  - SEND:
    - LVDS_OUT = shift_reg[3:0], LVDS_FRAME = 1. Nibble order is LSB first: bits [3:0], then [7:4], ... [31:28].
    - Each cycle: shift register shifts right 4, nib_cnt++.
    - Word prefetch:
      - When nib_cnt == 6 and the current word is not the last: rd_en = 1, rd_addr = word_cnt + 1.
      - At the edge ending nib_cnt == 7: shift_reg <= rd_data, word_cnt++, nib_cnt <= 0.
      - Result: no gap between words.
    - On the last nibble of the last word: at the next edge return to IDLE, LVDS_FRAME = 0, busy = 0, toggle done_toggle.
- Frame length:
  - LVDS_FRAME is high for exactly len*8 consecutive cycles.
  - First frame nibble appears 3 cycles after start_pulse (IDLE -> LOAD -> PRIME -> SEND, registered outputs).
  - rd_addr wraps never; the maximum address is 2^ADDR_W - 1.
- rd_en is a single-cycle pulse per word. It is 0 in IDLE, in PRIME, and for the last word's prefetch slot.
- Start while not IDLE: start_pulse is ignored. The sync chain still tracks the input, so a toggle during a frame is lost, not queued.
- Two toggles arriving within 1 cycle at the synchroniser cancel. The AXI side must not re-toggle before done_toggle changes.
- len_words changes mid-frame: no effect; the latched value is used.
- Reset mid-frame:
  - All outputs return immediately (asynchronously) to reset values. done_toggle is not toggled.
  - The AXI side must resynchronise: done_toggle is reset to 0 and start_toggle must also be reset to 0 by the AXI-side reset.

Test Plan:
- Reset then idle: after lvds_resetn release, with no toggle for 20 cycles -> LVDS_OUT=IDLE_PATTERN, LVDS_FRAME=0, rd_en=0, busy=0.
- Single word: len_words=1, buffer[0]=32'h87654321, toggle start -> LVDS_FRAME high 8 cycles starting 3 cycles after start_pulse. LVDS_OUT sequence 1,2,3,4,5,6,7,8. Then done_toggle flips and busy=0.
- Multi-word, no gaps: len_words=3, words 32'h0000000F, 32'hF0000000, 32'hA5A5A5A5 -> 24 contiguous frame cycles.
  - Nibbles F,0,0,0,0,0,0,0,0,0,0,0,0,0,0,F,5,A,5,A,5,A,5,A.
  - rd_en pulses with rd_addr 0, 1, 2 at LOAD and at nib_cnt==6 of words 0 and 1 only.
- Full buffer: len_words=0 -> 1024 frame cycles, last rd_addr = 127, no read beyond.
- Start during frame: toggle again at frame cycle 10 of a 2-word frame -> frame completes at 16 cycles, no second frame, exactly one done_toggle change.
- Reset mid-frame: deassert lvds_resetn at frame cycle 5 -> same cycle LVDS_FRAME=0, LVDS_OUT=IDLE_PATTERN, busy=0. After release plus a new toggle, a full correct frame is sent from word 0.
